// File: rtl/vco_edge_decimator.sv
// vco_edge_decimator: counts rising VCO edges per decimation window and emits the count and its first difference
module vco_edge_decimator #(
  parameter int CNT_W = 8,
  parameter int DEC_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dff_in,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W:0]   delta_out,
  output logic             valid_out,
  output logic             ovf_out
);
  localparam int WW = $clog2(DEC_LEN);
  localparam logic [WW-1:0] LAST = WW'(DEC_LEN - 1);
  typedef enum logic {FIRST, RUN} state_t;
  state_t state;
  logic prev, ovf, rise, win_end, sat_hit;
  logic [WW-1:0] wcnt;
  logic [CNT_W-1:0] acc, last_count, total, base;
  logic [CNT_W:0] sum;
  // rising-edge detect, saturating accumulate and window-close decode
  always_comb begin
    rise = dff_in & ~prev;
    sum = {1'b0, acc} + {{CNT_W{1'b0}}, rise};
    sat_hit = sum[CNT_W];
    total = sat_hit ? '1 : sum[CNT_W-1:0];
    win_end = en && wcnt == LAST;
    base = state == FIRST ? '0 : last_count;
  end
  // window progress, edge accumulation and registered result update at window close
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FIRST;
      prev <= 1'b0;
      wcnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
      last_count <= '0;
      count_out <= '0;
      delta_out <= '0;
      valid_out <= 1'b0;
      ovf_out <= 1'b0;
    end else begin
      prev <= dff_in;
      valid_out <= 1'b0;
      if (en) begin
        wcnt <= win_end ? '0 : wcnt + 1'b1;
        if (win_end) begin
          count_out <= total;
          delta_out <= {1'b0, total} - {1'b0, base};
          ovf_out <= ovf | sat_hit;
          last_count <= total;
          acc <= '0;
          ovf <= 1'b0;
          valid_out <= 1'b1;
          state <= RUN;
        end else begin
          acc <= total;
          ovf <= ovf | sat_hit;
        end
      end
    end
endmodule

// File: tb/tb_vco_edge_decimator.sv
// tb_vco_edge_decimator: scoreboard bench for two widths of the edge decimator against a window-level edge-count model
module tb_vco_edge_decimator;
  logic clk = 0, rst = 1, en = 0, dff_in = 0;
  logic [7:0] count8;
  logic [8:0] delta8;
  logic valid8, ovf8;
  logic [2:0] count3;
  logic [3:0] delta3;
  logic valid3, ovf3;
  typedef struct {int c; int d; int o;} exp_t;
  exp_t q8[$], q3[$];
  int checks = 0, failures = 0;
  int m_prev = 0, m_edges = 0, m_pos = 0, m_last8 = 0, m_last3 = 0;

  always #5 clk = ~clk;

  vco_edge_decimator #(.CNT_W(8), .DEC_LEN(16)) dut8 (.clk(clk), .rst(rst), .en(en), .dff_in(dff_in),
    .count_out(count8), .delta_out(delta8), .valid_out(valid8), .ovf_out(ovf8));
  vco_edge_decimator #(.CNT_W(3), .DEC_LEN(16)) dut3 (.clk(clk), .rst(rst), .en(en), .dff_in(dff_in),
    .count_out(count3), .delta_out(delta3), .valid_out(valid3), .ovf_out(ovf3));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: count enabled rising edges over DEC_LEN enabled cycles, clamp to the output width
  task automatic tick(input bit e, input bit d);
    int r, c8, c3;
    en = e;
    dff_in = d;
    @(posedge clk);
    r = (d && m_prev == 0) ? 1 : 0;
    if (e) begin
      m_edges += r;
      m_pos++;
      if (m_pos == 16) begin
        c8 = m_edges > 255 ? 255 : m_edges;
        c3 = m_edges > 7 ? 7 : m_edges;
        q8.push_back('{c8, c8 - m_last8, m_edges > 255});
        q3.push_back('{c3, c3 - m_last3, m_edges > 7});
        m_last8 = c8;
        m_last3 = c3;
        m_edges = 0;
        m_pos = 0;
      end
    end
    m_prev = d;
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    m_prev = 0; m_edges = 0; m_pos = 0; m_last8 = 0; m_last3 = 0;
    q8.delete();
    q3.delete();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // monitor: every negedge the strobe must match scoreboard occupancy; pop and compare on strobe
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      chk("rst_count8", count8, 0);
      chk("rst_delta8", delta8, 0);
      chk("rst_valid8", valid8, 0);
      chk("rst_ovf8", ovf8, 0);
      chk("rst_count3", count3, 0);
      chk("rst_valid3", valid3, 0);
    end else begin
      chk("valid8", valid8, q8.size() != 0);
      if (q8.size() != 0) begin
        x = q8.pop_front();
        if (valid8) begin
          chk("count8", count8, x.c);
          chk("delta8", $signed(delta8), x.d);
          chk("ovf8", ovf8, x.o);
        end
      end
      chk("valid3", valid3, q3.size() != 0);
      if (q3.size() != 0) begin
        x = q3.pop_front();
        if (valid3) begin
          chk("count3", count3, x.c);
          chk("delta3", $signed(delta3), x.d);
          chk("ovf3", ovf3, x.o);
        end
      end
    end
  end

  initial begin
    int mode, per;
    bit d;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 64; i++) tick(1, ((i / 2) % 2) != 0);
    do_reset();
    for (int i = 0; i < 32; i++) tick(1, 1);
    do_reset();
    for (int i = 0; i < 32; i++) tick(1, (i % 2) != 0);
    do_reset();
    for (int i = 0; i < 40; i++) tick(!(i >= 8 && i < 16), ((i / 2) % 2) != 0);
    do_reset();
    for (int i = 0; i < 9; i++) tick(1, ((i / 2) % 2) != 0);
    do_reset();
    for (int i = 0; i < 20; i++) tick(1, ((i / 2) % 2) != 0);
    do_reset();
    for (int i = 0; i < 32; i++) tick(1, i == 15);
    mode = 0;
    per = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        mode = $urandom_range(0, 2);
        per = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      d = mode == 0 ? $urandom_range(0, 1) != 0 : mode == 1 ? (i % 2) != 0 : ((i / per) % 2) != 0;
      tick($urandom_range(0, 9) != 0, d);
    end
    tick(0, 0);
    tick(0, 0);
    @(negedge clk);
    #1;
    chk("drain8", q8.size(), 0);
    chk("drain3", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
